// File: rtl/rx_medidas_7e1_if.sv
// ---------------------------------------------------------------------------
// rx_medidas_7e1_if
//   Bundles the serial input line and the measurement outputs of the
//   rx_medidas_7e1 frame receiver.
//
//   Signals
//     RX        serial 7E1 line, idle high (driven by the line side)
//     medida1-3 last valid BCD distance per sensor, {hundreds, tens, units}
//     pronto    one-cycle pulse, a complete valid frame updated medida1..3
//     erro      one-cycle pulse, character or frame format error
//     db_estado frame parser state, for debug (0 = SYNC)
//
//   Modports
//     master  receiver side: consumes RX, drives the results
//     slave   line/consumer side: drives RX, reads the results
// ---------------------------------------------------------------------------
interface rx_medidas_7e1_if;
  logic        RX;
  logic [11:0] medida1;
  logic [11:0] medida2;
  logic [11:0] medida3;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  modport master (
    input  RX,
    output medida1, medida2, medida3, pronto, erro, db_estado
  );

  modport slave (
    output RX,
    input  medida1, medida2, medida3, pronto, erro, db_estado
  );
endinterface

// File: rtl/rx_medidas_7e1.sv
// ---------------------------------------------------------------------------
// rx_medidas_7e1
//   Receives 7E1 serial characters and parses 12-character measurement
//   frames "ddd#ddd#ddd#" (three BCD distances, one per sensor). A complete
//   valid frame updates medida1..3 together and pulses pronto; a bad
//   character, bad format, framing error or a mid-frame idle gap pulses erro
//   and drops the frame.
//
//   Parameters
//     BAUD_DIV  clock cycles per serial bit
//     GAP_BITS  idle bit-times that resynchronise the frame parser
//
//   Ports
//     clock     rising-edge clock
//     reset     synchronous, active-low reset
//     bus       rx_medidas_7e1_if.master (RX in; medida1..3, pronto, erro,
//               db_estado out)
//
//   Configuration
//     PARITY_CHECK_EN  when defined, a received parity bit that does not
//                      match even parity over the 7 data bits is treated as
//                      a character error. When undefined, the parity bit is
//                      sampled and discarded.
// ---------------------------------------------------------------------------
module rx_medidas_7e1 #(
  parameter int BAUD_DIV = 434,
  parameter int GAP_BITS = 20
) (
  input  logic              clock,
  input  logic              reset,
  rx_medidas_7e1_if.master  bus
);

  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int GAP_LEN  = GAP_BITS * BAUD_DIV;
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);
  localparam int GAP_W    = $clog2(GAP_LEN + 1);

  // -------------------------------------------------------------------------
  // Input synchroniser and edge history
  // -------------------------------------------------------------------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic rx_sync;

  assign rx_sync = rx_s2_q;

  // Reset to the idle level so that leaving reset never looks like a start edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= bus.RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // -------------------------------------------------------------------------
  // Character receiver
  //   bit_idx 0 = start re-check, 1..7 = data LSB first, 8 = parity, 9 = stop
  // -------------------------------------------------------------------------
  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_BUSY = 1'b1
  } rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_idx_q,  bit_idx_d;
  logic [6:0]       data_q,     data_d;
  logic             char_done;
  logic             char_err;
  logic             par_err;

`ifdef PARITY_CHECK_EN
  logic par_q, par_d;
  assign par_err = (par_q != (^data_q));
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
`ifdef PARITY_CHECK_EN
    par_d      = par_q;
`endif
    char_done  = 1'b0;
    char_err   = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync) begin
          rx_state_d = RX_BUSY;
          baud_cnt_d = CNT_W'(HALF_DIV - 1);
          bit_idx_d  = 4'd0;
        end
      end

      RX_BUSY: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - CNT_W'(1);
        end else begin
          baud_cnt_d = CNT_W'(BAUD_DIV - 1);
          bit_idx_d  = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd0) begin
            // Glitch rejection: a start bit that is high again at mid-bit is dropped.
            if (rx_sync) rx_state_d = RX_IDLE;
          end else if (bit_idx_q <= 4'd7) begin
            data_d = {rx_sync, data_q[6:1]};
          end else if (bit_idx_q == 4'd8) begin
`ifdef PARITY_CHECK_EN
            par_d = rx_sync;
`endif
          end else begin
            // Stop sample: return to idle at once so a start edge on the very
            // next cycle is caught by the edge detector.
            rx_state_d = RX_IDLE;
            char_done  = 1'b1;
            char_err   = !rx_sync || par_err;
          end
        end
      end

      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
`ifdef PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
`ifdef PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Idle-gap detector: one pulse after GAP_LEN consecutive high cycles,
  // then holds until the line goes low again.
  // -------------------------------------------------------------------------
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             gap_evt;

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    gap_evt   = 1'b0;
    if (!rx_sync) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != GAP_W'(GAP_LEN)) begin
      gap_cnt_d = gap_cnt_q + GAP_W'(1);
      if (gap_cnt_q == GAP_W'(GAP_LEN - 1)) gap_evt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) gap_cnt_q <= '0;
    else        gap_cnt_q <= gap_cnt_d;
  end

  // -------------------------------------------------------------------------
  // Frame parser
  // -------------------------------------------------------------------------
  typedef enum logic [3:0] {
    P_SYNC = 4'd0,
    P_DIG0 = 4'd1,
    P_DIG1 = 4'd2,
    P_DIG2 = 4'd3,
    P_HASH = 4'd4
  } p_state_t;

  p_state_t    p_state_q, p_state_d;
  logic [1:0]  sensor_q,  sensor_d;
  logic [11:0] shadow_q [3];
  logic [11:0] shadow_d [3];
  logic [11:0] medida1_q, medida1_d;
  logic [11:0] medida2_q, medida2_d;
  logic [11:0] medida3_q, medida3_d;
  logic        pronto_q,  pronto_d;
  logic        erro_q,    erro_d;
  logic        is_digit;
  logic        is_hash;

  assign is_digit = (data_q[6:4] == 3'b011) && (data_q[3:0] <= 4'd9);
  assign is_hash  = (data_q == 7'h23);

  always_comb begin
    p_state_d = p_state_q;
    sensor_d  = sensor_q;
    shadow_d  = shadow_q;
    medida1_d = medida1_q;
    medida2_d = medida2_q;
    medida3_d = medida3_q;
    pronto_d  = 1'b0;
    erro_d    = 1'b0;

    if (char_done) begin
      // Characters (good or bad) are ignored entirely while unsynchronised.
      if (p_state_q != P_SYNC) begin
        if (char_err) begin
          erro_d    = 1'b1;
          p_state_d = P_SYNC;
        end else begin
          case (p_state_q)
            P_DIG0: begin
              if (is_digit) begin
                shadow_d[sensor_q][11:8] = data_q[3:0];
                p_state_d = P_DIG1;
              end else begin
                erro_d    = 1'b1;
                p_state_d = P_SYNC;
              end
            end
            P_DIG1: begin
              if (is_digit) begin
                shadow_d[sensor_q][7:4] = data_q[3:0];
                p_state_d = P_DIG2;
              end else begin
                erro_d    = 1'b1;
                p_state_d = P_SYNC;
              end
            end
            P_DIG2: begin
              if (is_digit) begin
                shadow_d[sensor_q][3:0] = data_q[3:0];
                p_state_d = P_HASH;
              end else begin
                erro_d    = 1'b1;
                p_state_d = P_SYNC;
              end
            end
            P_HASH: begin
              if (is_hash) begin
                p_state_d = P_DIG0;
                if (sensor_q == 2'd2) begin
                  // Publish all three readings atomically.
                  medida1_d = shadow_q[0];
                  medida2_d = shadow_q[1];
                  medida3_d = shadow_q[2];
                  pronto_d  = 1'b1;
                  sensor_d  = 2'd0;
                end else begin
                  sensor_d = sensor_q + 2'd1;
                end
              end else begin
                erro_d    = 1'b1;
                p_state_d = P_SYNC;
              end
            end
            default: p_state_d = P_SYNC;
          endcase
        end
      end
    end else if (gap_evt) begin
      if (p_state_q == P_SYNC) begin
        p_state_d = P_DIG0;
        sensor_d  = 2'd0;
      end else if (!((p_state_q == P_DIG0) && (sensor_q == 2'd0))) begin
        // Line went idle part-way through a frame.
        erro_d    = 1'b1;
        p_state_d = P_DIG0;
        sensor_d  = 2'd0;
      end
    end

    if (erro_d) pronto_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      p_state_q <= P_SYNC;
      sensor_q  <= '0;
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
      medida1_q <= '0;
      medida2_q <= '0;
      medida3_q <= '0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      p_state_q <= p_state_d;
      sensor_q  <= sensor_d;
      for (int i = 0; i < 3; i++) shadow_q[i] <= shadow_d[i];
      medida1_q <= medida1_d;
      medida2_q <= medida2_d;
      medida3_q <= medida3_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
    end
  end

  assign bus.medida1   = medida1_q;
  assign bus.medida2   = medida2_q;
  assign bus.medida3   = medida3_q;
  assign bus.pronto    = pronto_q;
  assign bus.erro      = erro_q;
  assign bus.db_estado = p_state_q;

endmodule
